// File: rtl/jcond_pkg.sv
// -----------------------------------------------------------------------------
// jcond_pkg
// Shared definitions for the jump-condition evaluation stage:
//   * condition-code values COND_Z .. COND_BLC (codes above COND_BLC are reserved)
//   * R0 flag bit indices R0_Z .. R0_X (R0 is declared [0:8], bit 0 = Z)
//   * FSM state encoding used by jcond_eval
//   * cond_reserved(): true for the reserved codes 13-15
// Optional feature macro used by the importing files: JCOND_INV_EN.
// -----------------------------------------------------------------------------
package jcond_pkg;

    // Condition codes. 0-8 test a single R0 flag whose index equals the code.
    localparam logic [3:0] COND_Z   = 4'd0;
    localparam logic [3:0] COND_M   = 4'd1;
    localparam logic [3:0] COND_V   = 4'd2;   // taken result also clears V
    localparam logic [3:0] COND_C   = 4'd3;
    localparam logic [3:0] COND_L   = 4'd4;
    localparam logic [3:0] COND_E   = 4'd5;
    localparam logic [3:0] COND_G   = 4'd6;
    localparam logic [3:0] COND_Y   = 4'd7;
    localparam logic [3:0] COND_X   = 4'd8;
    localparam logic [3:0] COND_NE  = 4'd9;   // ~E
    localparam logic [3:0] COND_LE  = 4'd10;  // L | E
    localparam logic [3:0] COND_GE  = 4'd11;  // G | E
    localparam logic [3:0] COND_BLC = 4'd12;  // all masked flags set

    // R0 flag bit positions.
    localparam int R0_Z = 0;
    localparam int R0_M = 1;
    localparam int R0_V = 2;
    localparam int R0_C = 3;
    localparam int R0_L = 4;
    localparam int R0_E = 5;
    localparam int R0_G = 6;
    localparam int R0_Y = 7;
    localparam int R0_X = 8;

    // Evaluation sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_CLRV    = 3'd4
    } state_t;

    // Codes 13-15 are reserved and always resolve to not-taken with an error.
    function automatic logic cond_reserved(input logic [3:0] c);
        return (c > COND_BLC);
    endfunction

endpackage

// File: rtl/jcond_mux.sv
// -----------------------------------------------------------------------------
// jcond_mux
// Purely combinational condition resolver. Given a snapshot of the R0 flags,
// a condition code and a BLC mask, produces the taken/not-taken result and the
// reserved-code error flag.
//
// Ports:
//   i_snap  [0:8]  R0 flag snapshot (0=Z 1=M 2=V 3=C 4=L 5=E 6=G 7=Y 8=X)
//   i_cond  [3:0]  condition code
//   i_mask  [0:7]  BLC mask, aligned with i_snap[0:7]
//   i_inv          result inversion (only present with JCOND_INV_EN)
//   o_take         final result; always 0 for reserved codes
//   o_err          1 for reserved codes 13-15
//
// Optional feature macro: JCOND_INV_EN (adds i_inv).
// -----------------------------------------------------------------------------
module jcond_mux
    import jcond_pkg::*;
(
    input  logic [0:8] i_snap,
    input  logic [3:0] i_cond,
    input  logic [0:7] i_mask,
`ifdef JCOND_INV_EN
    input  logic       i_inv,
`endif
    output logic       o_take,
    output logic       o_err
);

    logic w_raw;
    logic w_res;

    always_comb begin
        w_raw = 1'b0;
        case (i_cond)
            COND_Z:   w_raw = i_snap[R0_Z];
            COND_M:   w_raw = i_snap[R0_M];
            COND_V:   w_raw = i_snap[R0_V];
            COND_C:   w_raw = i_snap[R0_C];
            COND_L:   w_raw = i_snap[R0_L];
            COND_E:   w_raw = i_snap[R0_E];
            COND_G:   w_raw = i_snap[R0_G];
            COND_Y:   w_raw = i_snap[R0_Y];
            COND_X:   w_raw = i_snap[R0_X];
            COND_NE:  w_raw = ~i_snap[R0_E];
            COND_LE:  w_raw = i_snap[R0_L] | i_snap[R0_E];
            COND_GE:  w_raw = i_snap[R0_G] | i_snap[R0_E];
            // Every mask bit must find its flag set; an empty mask is trivially met.
            COND_BLC: w_raw = ((i_snap[R0_Z:R0_Y] & i_mask) == i_mask);
            default:  w_raw = 1'b0;
        endcase
    end

    assign w_res = cond_reserved(i_cond);

`ifdef JCOND_INV_EN
    // Inversion applies to real codes only; reserved codes stay not-taken.
    assign o_take = ~w_res & (w_raw ^ i_inv);
`else
    assign o_take = ~w_res & w_raw;
`endif
    assign o_err  = w_res;

endmodule

// File: rtl/jcond_eval.sv
// -----------------------------------------------------------------------------
// jcond_eval
// Condition-evaluation stage downstream of the R0 state register. On a request
// it waits out any pending R0 flag update, takes one snapshot of R0, resolves
// the condition through jcond_mux and reports taken/not-taken. A taken V test
// additionally drives a V-clear pulse (_0_v) back into R0.
//
// Parameters:
//   WAIT_MAX  max cycles spent waiting on flag_busy before aborting (1..15)
//   CLRV_LEN  length of the _0_v pulse in cycles (1..3)
//
// Ports:
//   clk_sys        system clock, rising edge
//   zer_           asynchronous active-low reset
//   r0     [0:8]   R0 flags (0=Z 1=M 2=V 3=C 4=L 5=E 6=G 7=Y 8=X)
//   flag_busy      an R0 flag update is in flight
//   req            evaluation request pulse, accepted only when idle
//   cond   [3:0]   condition code, captured with req
//   mask   [0:7]   BLC mask, captured with req
//   inv            result inversion, captured with req (JCOND_INV_EN only)
//   busy           high while an evaluation is in progress (state != IDLE)
//   done           one-cycle completion pulse
//   take           result, stable from done until the next accepted req
//   err            one-cycle pulse with done: reserved code or wait timeout
//   _0_v           V-clear pulse to R0
//
// Optional feature macro: JCOND_INV_EN.
//
// Every output is a flop; r0 is only ever written into the snapshot register,
// so there is no combinational path from r0 to an output. The cycle in which
// done is high is spent in the state that produced it (RESOLVE, CLRV or WAIT)
// so a req arriving alongside done is not accepted.
// -----------------------------------------------------------------------------
module jcond_eval
    import jcond_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CLRV_LEN = 2
) (
    input  logic       clk_sys,
    input  logic       zer_,
    input  logic [0:8] r0,
    input  logic       flag_busy,
    input  logic       req,
    input  logic [3:0] cond,
    input  logic [0:7] mask,
`ifdef JCOND_INV_EN
    input  logic       inv,
`endif
    output logic       busy,
    output logic       done,
    output logic       take,
    output logic       err,
    output logic       _0_v
);

    // Last wait-counter value before the timeout fires, and the value it
    // settles on when the timeout does fire.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
    localparam logic [3:0] WAIT_TOP  = 4'(WAIT_MAX);
    // _0_v cycle count at which done must be scheduled for the final CLRV cycle.
    localparam logic [1:0] CLRV_LAST = 2'(CLRV_LEN - 1);

    state_t     r_state;
    logic [3:0] r_cond;
    logic [0:7] r_mask;
    logic [0:8] r_snap;
    logic [3:0] r_wait_cnt;
    logic [1:0] r_clrv_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_take;
    logic       r_err;
    logic       r_clrv;
`ifdef JCOND_INV_EN
    logic       r_inv;
`endif

    logic       w_take;
    logic       w_err;
    logic       w_clrv_req;

    jcond_mux u_mux (
        .i_snap (r_snap),
        .i_cond (r_cond),
        .i_mask (r_mask),
`ifdef JCOND_INV_EN
        .i_inv  (r_inv),
`endif
        .o_take (w_take),
        .o_err  (w_err)
    );

    // w_take is already the final (possibly inverted) result, so an inverted
    // V test that ends up not-taken never clears V.
    assign w_clrv_req = (r_cond == COND_V) & w_take;

    always_ff @(posedge clk_sys or negedge zer_) begin
        if (!zer_) begin
            r_state    <= ST_IDLE;
            r_cond     <= 4'd0;
            r_mask     <= 8'd0;
            r_snap     <= 9'd0;
            r_wait_cnt <= 4'd0;
            r_clrv_cnt <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_take     <= 1'b0;
            r_err      <= 1'b0;
            r_clrv     <= 1'b0;
`ifdef JCOND_INV_EN
            r_inv      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    r_clrv <= 1'b0;
                    if (req) begin
                        r_cond     <= cond;
                        r_mask     <= mask;
`ifdef JCOND_INV_EN
                        r_inv      <= inv;
`endif
                        r_wait_cnt <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= flag_busy ? ST_WAIT : ST_SAMPLE;
                    end
                end

                ST_WAIT: begin
                    if (r_done) begin
                        // Timeout completion cycle.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (!flag_busy) begin
                        r_state <= ST_SAMPLE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Still busy after WAIT_MAX wait cycles: give up.
                        r_wait_cnt <= WAIT_TOP;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_take     <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    // The only cycle r0 is read. A flag_busy that rises now is
                    // ignored: the updater gives one cycle of setup.
                    r_snap  <= r0;
                    r_state <= ST_RESOLVE;
                end

                ST_RESOLVE: begin
                    if (r_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end else begin
                        r_take <= w_take;
                        r_err  <= w_err;
                        if (w_clrv_req) begin
                            r_state    <= ST_CLRV;
                            r_clrv     <= 1'b1;
                            r_clrv_cnt <= 2'd1;
                            // A one-cycle pulse completes in its only cycle.
                            if (CLRV_LEN == 1) begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                ST_CLRV: begin
                    if (r_done) begin
                        // Last _0_v cycle just completed; drop the pulse.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_clrv  <= 1'b0;
                    end else begin
                        if (r_clrv_cnt == CLRV_LAST) begin
                            r_done <= 1'b1;
                        end
                        r_clrv_cnt <= r_clrv_cnt + 2'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_clrv  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign take = r_take;
    assign err  = r_err;
    assign _0_v = r_clrv;

endmodule
